sfo_hypothesis_sweeper: RTL and testbench

- Sequencer that sits directly around the SFO FFT correlator.
- For each SFO hypothesis in a programmed sweep, it pulses the correlator reset with the hypothesis applied, then replays one stored FFT-magnitude frame from a bin buffer as correlation updates.
- It collects each correlation result and reports the best threshold-qualified hypothesis to the gateway control logic.

---
 rtl/sfo_hypothesis_sweeper.sv | 226 ++++++++++++++++++++++
 tb/tb_sfo_hypothesis_sweeper.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sfo_hypothesis_sweeper.sv
// Sweeps SFO hypotheses around the FFT correlator: one frame replay per hypothesis, best qualified result kept.
// Optional macro SFO_SWEEP_NEIGHBOR_EN adds best_corr_prev/best_corr_next for downstream interpolation.
module sfo_hypothesis_sweeper #(
    parameter int FFT_LEN_LOG2    = 9,
    parameter int POWER_WIDTH     = 16,
    parameter int FFT_SHIFT_WIDTH = 4,
    parameter int SFO_INT_WIDTH   = 9,
    parameter int SFO_FRAC_WIDTH  = 16,
    parameter int CORR_WIDTH      = 27,
    parameter int MAX_HYP_LOG2    = 8,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    start,
    input  logic                                    abort,
    input  logic [SFO_INT_WIDTH-1:0]                sfo_start_int,
    input  logic [SFO_FRAC_WIDTH-1:0]               sfo_start_frac,
    input  logic [SFO_INT_WIDTH+SFO_FRAC_WIDTH-1:0] sfo_step,
    input  logic [MAX_HYP_LOG2-1:0]                 num_hyp,
    output logic [FFT_LEN_LOG2-1:0]                 bin_rd_addr,
    output logic                                    bin_rd_en,
    input  logic [POWER_WIDTH-1:0]                  bin_rd_mag,
    input  logic [FFT_SHIFT_WIDTH-1:0]              bin_rd_exp,
    output logic [SFO_INT_WIDTH-1:0]                sfo_int_part,
    output logic [SFO_FRAC_WIDTH-1:0]               sfo_frac_part,
    output logic                                    correlation_reset,
    output logic                                    correlation_update,
    output logic [POWER_WIDTH-1:0]                  fft_mag_out,
    output logic [FFT_SHIFT_WIDTH-1:0]              fft_mag_exponent_out,
    input  logic [CORR_WIDTH-1:0]                   correlation_in,
    input  logic                                    correlation_in_valid,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    best_found,
    output logic [MAX_HYP_LOG2-1:0]                 best_index,
    output logic [CORR_WIDTH-2:0]                   best_corr,
    output logic [SFO_INT_WIDTH+SFO_FRAC_WIDTH-1:0] best_sfo,
`ifdef SFO_SWEEP_NEIGHBOR_EN
    output logic [CORR_WIDTH-2:0]                   best_corr_prev,
    output logic [CORR_WIDTH-2:0]                   best_corr_next,
`endif
    output logic [MAX_HYP_LOG2-1:0]                 timeout_count
);
    localparam int SFO_W   = SFO_INT_WIDTH + SFO_FRAC_WIDTH;
    localparam int MAG_W   = CORR_WIDTH - 1;
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0]      TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FFT_LEN_LOG2-1:0] ADDR_LAST  = '1;
    localparam logic [MAX_HYP_LOG2-1:0] HYP_ONE    = MAX_HYP_LOG2'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CRESET, S_STREAM, S_DRAIN, S_WAIT, S_DONE
    } state_t;

    state_t                    state_reg, state_next;
    logic [FFT_LEN_LOG2-1:0]   addr_reg;
    logic [TIMER_W-1:0]        timer_reg;
    logic [MAX_HYP_LOG2-1:0]   idx_reg;
    logic [MAX_HYP_LOG2-1:0]   last_idx_reg;
    logic [SFO_W-1:0]          hyp_reg;
    logic [SFO_W-1:0]          start_hyp_reg;
    logic [SFO_W-1:0]          step_reg;
    logic                      upd_reg;
    logic                      best_found_reg;
    logic [MAX_HYP_LOG2-1:0]   best_index_reg;
    logic [MAG_W-1:0]          best_corr_reg;
    logic [SFO_W-1:0]          best_sfo_reg;
    logic [MAX_HYP_LOG2-1:0]   timeout_count_reg;

    logic                      result_accept;
    logic                      timeout_hit;
    logic                      start_accept;
    logic                      capture;
    logic                      in_flag;
    logic [MAG_W-1:0]          in_mag;

    assign in_flag      = correlation_in[CORR_WIDTH-1];
    assign in_mag       = correlation_in[MAG_W-1:0];
    assign start_accept = (state_reg == S_IDLE) && start && !abort;
    assign capture      = result_accept && in_flag && (!best_found_reg || (in_mag > best_corr_reg));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        result_accept = 1'b0;
        timeout_hit   = 1'b0;
        case (state_reg)
            S_IDLE:   if (start) state_next = S_LOAD;
            S_LOAD:   state_next = S_CRESET;
            S_CRESET: state_next = S_STREAM;
            S_STREAM: if (addr_reg == ADDR_LAST) state_next = S_DRAIN;
            S_DRAIN:  state_next = S_WAIT;
            S_WAIT: begin
                // A result arriving on the final timer cycle still wins over the timeout.
                if (correlation_in_valid) begin
                    result_accept = 1'b1;
                end else if (timer_reg == TIMER_LAST) begin
                    timeout_hit = 1'b1;
                end
                if (correlation_in_valid || (timer_reg == TIMER_LAST)) begin
                    state_next = (idx_reg == last_idx_reg) ? S_DONE : S_LOAD;
                end
            end
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
        if (abort) begin
            state_next    = S_IDLE;
            result_accept = 1'b0;
            timeout_hit   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_reg          <= '0;
            timer_reg         <= '0;
            idx_reg           <= '0;
            last_idx_reg      <= '0;
            hyp_reg           <= '0;
            start_hyp_reg     <= '0;
            step_reg          <= '0;
            upd_reg           <= 1'b0;
            best_found_reg    <= 1'b0;
            best_index_reg    <= '0;
            best_corr_reg     <= '0;
            best_sfo_reg      <= '0;
            timeout_count_reg <= '0;
        end else begin
            upd_reg <= (state_reg == S_STREAM) && !abort;
            if (start_accept) begin
                idx_reg           <= '0;
                last_idx_reg      <= (num_hyp == '0) ? '0 : (num_hyp - HYP_ONE);
                start_hyp_reg     <= {sfo_start_int, sfo_start_frac};
                step_reg          <= sfo_step;
                best_found_reg    <= 1'b0;
                best_index_reg    <= '0;
                best_corr_reg     <= '0;
                best_sfo_reg      <= '0;
                timeout_count_reg <= '0;
            end
            if (state_reg == S_LOAD) begin
                hyp_reg <= (idx_reg == '0) ? start_hyp_reg : (hyp_reg + step_reg);
            end
            if (state_reg == S_CRESET) addr_reg <= '0;
            if (state_reg == S_STREAM) addr_reg <= addr_reg + FFT_LEN_LOG2'(1);
            if (state_reg == S_DRAIN)  timer_reg <= '0;
            if (state_reg == S_WAIT)   timer_reg <= timer_reg + TIMER_W'(1);
            if (result_accept || timeout_hit) begin
                idx_reg <= idx_reg + HYP_ONE;
            end
            if (timeout_hit && (timeout_count_reg != '1)) begin
                timeout_count_reg <= timeout_count_reg + HYP_ONE;
            end
            if (capture) begin
                best_found_reg <= 1'b1;
                best_index_reg <= idx_reg;
                best_corr_reg  <= in_mag;
                best_sfo_reg   <= hyp_reg;
            end
        end
    end

`ifdef SFO_SWEEP_NEIGHBOR_EN
    logic [MAG_W-1:0] last_eff_reg;
    logic [MAG_W-1:0] prev_reg;
    logic [MAG_W-1:0] next_reg;
    logic             next_pending_reg;
    logic [MAG_W-1:0] eff_mag;

    // Unqualified and timed-out hypotheses contribute a zero magnitude.
    assign eff_mag = (result_accept && in_flag) ? in_mag : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_eff_reg     <= '0;
            prev_reg         <= '0;
            next_reg         <= '0;
            next_pending_reg <= 1'b0;
        end else if (start_accept) begin
            last_eff_reg     <= '0;
            prev_reg         <= '0;
            next_reg         <= '0;
            next_pending_reg <= 1'b0;
        end else if (result_accept || timeout_hit) begin
            last_eff_reg <= eff_mag;
            if (capture) begin
                prev_reg         <= last_eff_reg;
                next_reg         <= '0;
                next_pending_reg <= 1'b1;
            end else if (next_pending_reg) begin
                next_reg         <= eff_mag;
                next_pending_reg <= 1'b0;
            end
        end
    end

    assign best_corr_prev = prev_reg;
    assign best_corr_next = next_reg;
`endif

    assign bin_rd_en            = (state_reg == S_STREAM);
    assign bin_rd_addr          = addr_reg;
    assign correlation_reset    = (state_reg == S_CRESET);
    assign correlation_update   = upd_reg;
    assign fft_mag_out          = upd_reg ? bin_rd_mag : '0;
    assign fft_mag_exponent_out = upd_reg ? bin_rd_exp : '0;
    assign sfo_int_part         = hyp_reg[SFO_W-1:SFO_FRAC_WIDTH];
    assign sfo_frac_part        = hyp_reg[SFO_FRAC_WIDTH-1:0];
    assign busy                 = (state_reg != S_IDLE);
    assign done                 = (state_reg == S_DONE);
    assign best_found           = best_found_reg;
    assign best_index           = best_index_reg;
    assign best_corr            = best_corr_reg;
    assign best_sfo             = best_sfo_reg;
    assign timeout_count        = timeout_count_reg;

endmodule

// File: tb/tb_sfo_hypothesis_sweeper.sv
// Bench for sfo_hypothesis_sweeper: bin-buffer and correlator models plus a sweep-level reference model.
module tb_sfo_hypothesis_sweeper;
    localparam int NBINS = 512;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, abort;
    logic [8:0]  sfo_start_int;
    logic [15:0] sfo_start_frac;
    logic [24:0] sfo_step;
    logic [7:0]  num_hyp;
    logic [8:0]  bin_rd_addr;
    logic        bin_rd_en;
    logic [15:0] bin_rd_mag;
    logic [3:0]  bin_rd_exp;
    logic [8:0]  sfo_int_part;
    logic [15:0] sfo_frac_part;
    logic        correlation_reset, correlation_update;
    logic [15:0] fft_mag_out;
    logic [3:0]  fft_mag_exponent_out;
    logic [26:0] correlation_in;
    logic        correlation_in_valid;
    logic        busy, done, best_found;
    logic [7:0]  best_index;
    logic [25:0] best_corr;
    logic [24:0] best_sfo;
    logic [7:0]  timeout_count;
`ifdef SFO_SWEEP_NEIGHBOR_EN
    logic [25:0] best_corr_prev, best_corr_next;
`endif

    sfo_hypothesis_sweeper dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .sfo_start_int(sfo_start_int), .sfo_start_frac(sfo_start_frac),
        .sfo_step(sfo_step), .num_hyp(num_hyp),
        .bin_rd_addr(bin_rd_addr), .bin_rd_en(bin_rd_en),
        .bin_rd_mag(bin_rd_mag), .bin_rd_exp(bin_rd_exp),
        .sfo_int_part(sfo_int_part), .sfo_frac_part(sfo_frac_part),
        .correlation_reset(correlation_reset), .correlation_update(correlation_update),
        .fft_mag_out(fft_mag_out), .fft_mag_exponent_out(fft_mag_exponent_out),
        .correlation_in(correlation_in), .correlation_in_valid(correlation_in_valid),
        .busy(busy), .done(done), .best_found(best_found), .best_index(best_index),
        .best_corr(best_corr), .best_sfo(best_sfo),
`ifdef SFO_SWEEP_NEIGHBOR_EN
        .best_corr_prev(best_corr_prev), .best_corr_next(best_corr_next),
`endif
        .timeout_count(timeout_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Per-hypothesis correlator behaviour: result word and latency after the last update (<=0: never).
    logic [26:0] resp [0:15];
    int          lat  [0:15];
    logic [15:0] mem_mag [0:NBINS-1];
    logic [3:0]  mem_exp [0:NBINS-1];

    int          mon_h, mon_rd, mon_up, addr_err, data_err, order_err, done_cnt;
    int          upd_cnt [0:15];
    logic [8:0]  seen_int  [0:15];
    logic [15:0] seen_frac [0:15];
    int          p_h, p_up, p_cd;

    logic        exp_found;
    int          exp_idx, exp_to, n_eff;
    logic [25:0] exp_corr;
    logic [24:0] exp_sfo;
    logic [24:0] exp_hyp [0:15];
    logic [25:0] eff     [0:15];

    // Bin buffer (one-cycle read latency) and correlator model.
    initial begin
        logic       rd_pend;
        logic [8:0] rd_pend_addr;
        rd_pend = 1'b0; rd_pend_addr = '0;
        bin_rd_mag = '0; bin_rd_exp = '0;
        correlation_in = '0; correlation_in_valid = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rd_pend) begin
                bin_rd_mag = mem_mag[rd_pend_addr];
                bin_rd_exp = mem_exp[rd_pend_addr];
            end
            rd_pend = bin_rd_en; rd_pend_addr = bin_rd_addr;
            if (correlation_reset) begin
                correlation_in_valid = 1'b0; correlation_in = '0;
                p_up = 0; p_cd = -1; p_h++;
            end
            if (p_cd > 0) begin
                p_cd--;
                if (p_cd == 0) begin
                    correlation_in = resp[p_h-1];
                    correlation_in_valid = 1'b1;
                end
            end
            if (correlation_update) begin
                p_up++;
                if (p_up == NBINS && p_h > 0 && p_h <= 16 && lat[p_h-1] > 0) p_cd = lat[p_h-1];
            end
        end
    end

    // Observation at the falling edge; tasks compare the collected statistics.
    initial begin
        forever begin
            @(negedge clk);
            if (correlation_reset) begin
                if (mon_h < 16) begin
                    seen_int[mon_h]  = sfo_int_part;
                    seen_frac[mon_h] = sfo_frac_part;
                end
                mon_h++; mon_rd = 0; mon_up = 0;
            end
            if (bin_rd_en) begin
                if (mon_h == 0) order_err++;
                if (bin_rd_addr !== 9'(mon_rd)) addr_err++;
                mon_rd++;
            end
            if (correlation_update) begin
                if (mon_h == 0 || mon_h > 16 || mon_up >= NBINS) order_err++;
                else begin
                    upd_cnt[mon_h-1]++;
                    if (fft_mag_out !== mem_mag[mon_up] || fft_mag_exponent_out !== mem_exp[mon_up]) data_err++;
                end
                mon_up++;
            end else if (fft_mag_out !== '0 || fft_mag_exponent_out !== '0) begin
                data_err++;
            end
            if (done) done_cnt++;
        end
    end

    task automatic clear_monitors();
        mon_h = 0; mon_rd = 0; mon_up = 0;
        addr_err = 0; data_err = 0; order_err = 0; done_cnt = 0;
        for (int i = 0; i < 16; i++) upd_cnt[i] = 0;
        p_h = 0; p_up = 0; p_cd = -1;
    endtask

    // Reference: hypothesis i is start + i*step (mod 2^25); best is the largest qualified
    // magnitude, earliest index among equals.
    task automatic compute_model(input int n_prog, input logic [24:0] s0, input logic [24:0] st);
        logic [25:0] top;
        n_eff = (n_prog == 0) ? 1 : n_prog;
        exp_found = 1'b0; top = '0; exp_to = 0; exp_idx = 0;
        for (int i = 0; i < n_eff; i++) begin
            exp_hyp[i] = 25'((64'(s0) + 64'(i) * 64'(st)) & 64'h1FF_FFFF);
            eff[i] = (lat[i] > 0 && resp[i][26]) ? resp[i][25:0] : 26'd0;
            if (lat[i] <= 0) exp_to++;
            if (lat[i] > 0 && resp[i][26]) begin
                if (!exp_found || resp[i][25:0] > top) top = resp[i][25:0];
                exp_found = 1'b1;
            end
        end
        for (int i = n_eff - 1; i >= 0; i--)
            if (lat[i] > 0 && resp[i][26] && resp[i][25:0] == top) exp_idx = i;
        if (exp_to > 255) exp_to = 255;
        exp_corr = exp_found ? top : 26'd0;
        exp_sfo  = exp_found ? exp_hyp[exp_idx] : 25'd0;
        if (!exp_found) exp_idx = 0;
    endtask

    task automatic run_sweep(input int n_prog, input logic [24:0] s0, input logic [24:0] st);
        int budget;
        clear_monitors();
        sfo_start_int = s0[24:16]; sfo_start_frac = s0[15:0];
        sfo_step = st; num_hyp = 8'(n_prog);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        budget = ((n_prog == 0) ? 1 : n_prog) * (NBINS + 80) + 50;
        while (done_cnt == 0 && budget > 0) begin
            @(negedge clk); budget--;
        end
        @(negedge clk);
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL sweep_done_wait got no done within budget want done pulse");
        end
    endtask

    task automatic test_reset();
        logic [127:0] outs;
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        sfo_start_int = '0; sfo_start_frac = '0; sfo_step = '0; num_hyp = '0;
        repeat (3) @(negedge clk);
        outs = {busy, done, best_found, best_index, best_corr, best_sfo, timeout_count,
                sfo_int_part, sfo_frac_part, correlation_reset, correlation_update,
                bin_rd_en, bin_rd_addr, fft_mag_out, fft_mag_exponent_out};
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL reset_outputs got %h want 0", outs); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_plan_sweep();
        resp[0] = {1'b1, 26'h100}; resp[1] = {1'b1, 26'h300}; resp[2] = {1'b1, 26'h200};
        lat[0] = 3; lat[1] = 5; lat[2] = 2;
        run_sweep(3, {9'd10, 16'h0000}, 25'h0_8000);
        $display("plan sweep: best_index=%0d best_corr=%h best_sfo=%h", best_index, best_corr, best_sfo);
        checks++;
        if (mon_h !== 3) begin errors++; $display("FAIL plan_reset_count got %0d want 3", mon_h); end
        checks++;
        if ({seen_int[0], seen_frac[0], seen_int[1], seen_frac[1], seen_int[2], seen_frac[2]} !==
            {9'd10, 16'h0000, 9'd10, 16'h8000, 9'd11, 16'h0000}) begin
            errors++;
            $display("FAIL plan_hypotheses got %0d.%h %0d.%h %0d.%h want 10.0000 10.8000 11.0000",
                     seen_int[0], seen_frac[0], seen_int[1], seen_frac[1], seen_int[2], seen_frac[2]);
        end
        checks++;
        if (upd_cnt[0] !== NBINS || upd_cnt[1] !== NBINS || upd_cnt[2] !== NBINS) begin
            errors++;
            $display("FAIL plan_update_count got %0d %0d %0d want 512 each", upd_cnt[0], upd_cnt[1], upd_cnt[2]);
        end
        checks++;
        if (addr_err + data_err + order_err != 0) begin
            errors++;
            $display("FAIL plan_stream got addr_err=%0d data_err=%0d order_err=%0d want 0", addr_err, data_err, order_err);
        end
        checks++;
        if ({best_found, best_index, best_corr, best_sfo} !== {1'b1, 8'd1, 26'h300, 9'd10, 16'h8000}) begin
            errors++;
            $display("FAIL plan_best got found=%b idx=%0d corr=%h sfo=%h want 1 1 300 0a8000",
                     best_found, best_index, best_corr, best_sfo);
        end
        checks++;
        if (done_cnt !== 1 || busy !== 1'b0) begin
            errors++; $display("FAIL plan_done got done_cnt=%0d busy=%b want 1 0", done_cnt, busy);
        end
    endtask

    task automatic test_unqualified();
        for (int i = 0; i < 3; i++) begin
            resp[i] = {1'b0, 26'($urandom_range(1, 4095))}; lat[i] = 2 + i;
        end
        run_sweep(3, 25'($urandom), 25'($urandom));
        $display("unqualified sweep: best_found=%b done_cnt=%0d", best_found, done_cnt);
        checks++;
        if ({best_found, best_index, best_corr} !== '0 || done_cnt !== 1) begin
            errors++;
            $display("FAIL unqualified got found=%b idx=%0d corr=%h done_cnt=%0d want 0 0 0 1",
                     best_found, best_index, best_corr, done_cnt);
        end
    endtask

    task automatic test_timeout();
        resp[0] = {1'b1, 26'h400}; resp[1] = {1'b1, 26'h999}; resp[2] = {1'b1, 26'h450};
        lat[0] = 4; lat[1] = -1; lat[2] = 1;
        run_sweep(3, {9'd3, 16'h1234}, 25'h0_0100);
        $display("timeout sweep: timeout_count=%0d best_index=%0d", timeout_count, best_index);
        checks++;
        if (timeout_count !== 8'd1) begin
            errors++; $display("FAIL timeout_count got %0d want 1", timeout_count);
        end
        checks++;
        if ({best_found, best_index, best_corr, best_sfo} !== {1'b1, 8'd2, 26'h450, 9'd3, 16'h1434}) begin
            errors++;
            $display("FAIL timeout_best got found=%b idx=%0d corr=%h sfo=%h want 1 2 450 031434",
                     best_found, best_index, best_corr, best_sfo);
        end
    endtask

    task automatic test_tie();
        resp[0] = {1'b1, 26'h500}; resp[1] = {1'b1, 26'h100}; resp[2] = {1'b1, 26'h500};
        lat[0] = 2; lat[1] = 6; lat[2] = 3;
        run_sweep(3, 25'd0, 25'd7);
        $display("tie sweep: best_index=%0d best_corr=%h", best_index, best_corr);
        checks++;
        if (best_index !== 8'd0 || best_corr !== 26'h500) begin
            errors++; $display("FAIL tie_index got idx=%0d corr=%h want 0 500", best_index, best_corr);
        end
    endtask

    task automatic test_num_hyp_zero();
        resp[0] = {1'b1, 26'h042}; lat[0] = 2;
        run_sweep(0, {9'd200, 16'hABCD}, 25'h1_0000);
        $display("num_hyp=0 sweep: hypotheses=%0d best_sfo=%h", mon_h, best_sfo);
        checks++;
        if (mon_h !== 1 || best_sfo !== {9'd200, 16'hABCD} || best_corr !== 26'h042) begin
            errors++;
            $display("FAIL num_hyp_zero got hyps=%0d sfo=%h corr=%h want 1 c8abcd 042", mon_h, best_sfo, best_corr);
        end
    endtask

    task automatic test_random_sweeps();
        for (int it = 0; it < 5; it++) begin
            int n_prog, hyp_bad, upd_bad;
            logic [24:0] s0, st;
            n_prog = int'($urandom_range(0, 6));
            s0 = 25'($urandom); st = 25'($urandom);
            for (int i = 0; i < 16; i++) begin
                resp[i] = {($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, 26'($urandom_range(0, 7) * 256)};
                lat[i]  = ($urandom_range(0, 9) < 2) ? -1 : int'($urandom_range(1, 8));
            end
            compute_model(n_prog, s0, st);
            run_sweep(n_prog, s0, st);
            hyp_bad = 0; upd_bad = 0;
            for (int i = 0; i < n_eff; i++) begin
                if ({seen_int[i], seen_frac[i]} !== exp_hyp[i]) hyp_bad++;
                if (upd_cnt[i] !== NBINS) upd_bad++;
            end
            $display("random sweep %0d: n=%0d best_found=%b best_index=%0d best_corr=%h timeouts=%0d",
                     it, n_eff, best_found, best_index, best_corr, timeout_count);
            checks++;
            if (mon_h !== n_eff || hyp_bad != 0 || upd_bad != 0) begin
                errors++;
                $display("FAIL random_hyps got hyps=%0d bad_sfo=%0d bad_upd=%0d want %0d 0 0", mon_h, hyp_bad, upd_bad, n_eff);
            end
            checks++;
            if (addr_err + data_err + order_err != 0 || done_cnt !== 1) begin
                errors++;
                $display("FAIL random_stream got addr=%0d data=%0d order=%0d done=%0d want 0 0 0 1",
                         addr_err, data_err, order_err, done_cnt);
            end
            checks++;
            if ({best_found, best_index, best_corr, best_sfo, timeout_count} !==
                {exp_found, 8'(exp_idx), exp_corr, exp_sfo, 8'(exp_to)}) begin
                errors++;
                $display("FAIL random_best got %b %0d %h %h %0d want %b %0d %h %h %0d",
                         best_found, best_index, best_corr, best_sfo, timeout_count,
                         exp_found, exp_idx, exp_corr, exp_sfo, exp_to);
            end
`ifdef SFO_SWEEP_NEIGHBOR_EN
            checks++;
            if (best_corr_prev !== ((exp_found && exp_idx > 0) ? eff[exp_idx-1] : 26'd0) ||
                best_corr_next !== ((exp_found && exp_idx < n_eff - 1) ? eff[exp_idx+1] : 26'd0)) begin
                errors++;
                $display("FAIL random_neighbors got prev=%h next=%h", best_corr_prev, best_corr_next);
            end
`endif
        end
    endtask

    task automatic test_abort();
        int budget;
        resp[0] = {1'b1, 26'h123}; resp[1] = {1'b1, 26'h777}; resp[2] = {1'b1, 26'h888};
        lat[0] = 2; lat[1] = 2; lat[2] = 2;
        clear_monitors();
        sfo_start_int = 9'd1; sfo_start_frac = '0; sfo_step = 25'h1_0000; num_hyp = 8'd3;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        budget = 2 * (NBINS + 80);
        while (!(mon_h == 2 && mon_up >= 100) && budget > 0) begin
            @(negedge clk); budget--;
        end
        checks++;
        if (budget == 0) begin errors++; $display("FAIL abort_reach_stream got no second stream want one"); end
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        $display("abort mid-stream: busy=%b bin_rd_en=%b update=%b", busy, bin_rd_en, correlation_update);
        checks++;
        if ({busy, bin_rd_en, correlation_update, correlation_reset} !== 4'b0000) begin
            errors++;
            $display("FAIL abort_idle got busy=%b en=%b upd=%b creset=%b want 0 0 0 0",
                     busy, bin_rd_en, correlation_update, correlation_reset);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (done_cnt !== 0 || mon_h !== 2) begin
            errors++; $display("FAIL abort_no_done got done_cnt=%0d hyps=%0d want 0 2", done_cnt, mon_h);
        end
        checks++;
        if ({best_found, best_index, best_corr} !== {1'b1, 8'd0, 26'h123}) begin
            errors++;
            $display("FAIL abort_partial_best got %b %0d %h want 1 0 123", best_found, best_index, best_corr);
        end
        start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_beats_start got busy=%b want 0", busy); end
    endtask

    task automatic test_async_reset();
        int budget;
        logic [127:0] outs;
        resp[0] = {1'b1, 26'h077}; lat[0] = 2; lat[1] = -1;
        clear_monitors();
        sfo_start_int = 9'd5; sfo_start_frac = 16'h4000; sfo_step = 25'h0_4000; num_hyp = 8'd2;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        budget = 2 * (NBINS + 80);
        while (!(mon_h == 2 && upd_cnt[1] == NBINS) && budget > 0) begin
            @(negedge clk); budget--;
        end
        repeat (5) @(negedge clk);
        checks++;
        if (budget == 0 || busy !== 1'b1 || best_found !== 1'b1) begin
            errors++;
            $display("FAIL async_pre_state got budget=%0d busy=%b found=%b want busy 1 found 1", budget, busy, best_found);
        end
        #2 reset = 1'b1;
        #1;
        outs = {busy, done, best_found, best_index, best_corr, best_sfo, timeout_count,
                sfo_int_part, sfo_frac_part, correlation_reset, correlation_update,
                bin_rd_en, bin_rd_addr, fft_mag_out, fft_mag_exponent_out};
        $display("async reset mid-wait: outputs=%h", outs);
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL async_reset got %h want 0", outs); end
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < NBINS; i++) begin
            mem_mag[i] = 16'($urandom);
            mem_exp[i] = 4'($urandom);
        end
        for (int i = 0; i < 16; i++) begin resp[i] = '0; lat[i] = 1; end
        clear_monitors();
        test_reset();
        test_plan_sweep();
        test_unqualified();
        test_timeout();
        test_tie();
        test_num_hyp_zero();
        test_random_sweeps();
        test_abort();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
